ecc_dec_pipe: RTL

//  Multi-lane, pipelined extended-Hamming (SECDED) decoder with valid/ready streaming.

---
 rtl/ecc_pkg.sv | 74 +++++++
 rtl/ecc_dec_lane.sv | 53 +++++
 rtl/ecc_dec_pipe.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared definitions for the extended-Hamming (SECDED) decoder.
//   calc_m()        number of Hamming check bits for K information bits
//   calc_syndrome() XOR of the indices of the set bits 1..n of a codeword
//   correct_cw()    invert the codeword bit addressed by the syndrome
//   extract_q()     gather the information bits from non-power-of-2 positions
//   lane_res_t      per-lane decode result {q, syndrome, parity, sb_err, db_err}
// Functions work on maximum-width vectors; callers pass the real codeword
// length and narrow the results with a size cast.
package ecc_pkg;

    localparam int unsigned MAX_K = 64;
    localparam int unsigned MAX_M = 7;
    localparam int unsigned MAX_N = MAX_K + MAX_M;
    localparam int unsigned QIW   = $clog2(MAX_K);
    localparam int unsigned CIW   = $clog2(MAX_N + 1);

    // Bit 0 holds the overall parity p0, bits 1..MAX_N the Hamming positions.
    typedef logic [MAX_N:0] cw_t;

    typedef struct packed {
        logic [MAX_K-1:0] q;
        logic [MAX_M-1:0] syndrome;
        logic             parity;
        logic             sb_err;
        logic             db_err;
    } lane_res_t;

    // Smallest m with 2**m >= m + k + 1.
    function automatic int unsigned calc_m(input int unsigned k);
        int unsigned m;
        m = 0;
        for (int unsigned i = 1; i < 32; i++) begin
            if (m == 0 && (32'd1 << i) >= i + k + 1) begin
                m = i;
            end
        end
        return m;
    endfunction

    function automatic logic [MAX_M-1:0] calc_syndrome(input cw_t cw, input int unsigned n);
        logic [MAX_M-1:0] s;
        s = '0;
        for (int unsigned i = 1; i <= MAX_N; i++) begin
            if (i <= n && cw[i[CIW-1:0]]) begin
                s ^= MAX_M'(i);
            end
        end
        return s;
    endfunction

    function automatic cw_t correct_cw(input cw_t cw, input logic [MAX_M-1:0] s, input logic en);
        cw_t r;
        r = cw;
        if (en && (32'(s) <= MAX_N)) begin
            r[s] = ~r[s];
        end
        return r;
    endfunction

    function automatic logic [MAX_K-1:0] extract_q(input cw_t cw, input int unsigned n);
        logic [MAX_K-1:0] q;
        int unsigned      j;
        q = '0;
        j = 0;
        for (int unsigned i = 1; i <= MAX_N; i++) begin
            if (i <= n && (i & (i - 1)) != 0 && j < MAX_K) begin
                q[j[QIW-1:0]] = cw[i[CIW-1:0]];
                j++;
            end
        end
        return q;
    endfunction

endpackage

// File: rtl/ecc_dec_lane.sv
// ecc_dec_lane: combinational SECDED decode of one codeword.
//   cw_i      codeword, n+1 bits, p0 at LSB (P0_LSB=1) or MSB (P0_LSB=0)
//   q_o       corrected information bits
//   syn_o     Hamming syndrome (m bits)
//   parity_o  XOR of all codeword bits
//   sb_err_o  single-bit error, corrected in q_o
//   db_err_o  double-bit error, q_o uncorrected
module ecc_dec_lane import ecc_pkg::*; #(
    parameter int unsigned K      = 8,
    parameter bit          P0_LSB = 1'b1,
    localparam int unsigned M     = calc_m(K),
    localparam int unsigned N     = M + K
) (
    input  logic [N:0]   cw_i,
    output logic [K-1:0] q_o,
    output logic [M-1:0] syn_o,
    output logic         parity_o,
    output logic         sb_err_o,
    output logic         db_err_o
);

    cw_t       cw_norm;
    cw_t       cw_fix;
    lane_res_t res_full;
    logic      unused_res;

    always_comb begin
        // Normalise so that Hamming position j always sits at bit j.
        cw_norm = '0;
        if (P0_LSB) begin
            cw_norm[N:0] = cw_i;
        end else begin
            cw_norm[N:0] = {cw_i[N-1:0], cw_i[N]};
        end
        res_full          = '0;
        res_full.parity   = ^cw_i;
        res_full.syndrome = calc_syndrome(cw_norm, N);
        res_full.sb_err   = res_full.parity & (|res_full.syndrome);
        res_full.db_err   = ~res_full.parity & (|res_full.syndrome);
        cw_fix            = correct_cw(cw_norm, res_full.syndrome, res_full.sb_err);
        res_full.q        = extract_q(cw_fix, N);
    end

    assign q_o      = res_full.q[K-1:0];
    assign syn_o    = res_full.syndrome[M-1:0];
    assign parity_o = res_full.parity;
    assign sb_err_o = res_full.sb_err;
    assign db_err_o = res_full.db_err;

    // Upper bits of the generic result are always zero for this K.
    assign unused_res = ^{res_full.q, res_full.syndrome};

endmodule

// File: rtl/ecc_dec_pipe.sv
// ecc_dec_pipe: multi-lane pipelined SECDED decoder with valid/ready streaming,
// saturating error counters and a sticky first-uncorrectable-error log.
//   clk_i, rst_ni               clock, async active-low reset
//   s_valid_i/s_ready_o         input handshake; s_data_i LANES codewords, s_tag_i sideband
//   m_valid_o/m_ready_i         output handshake; m_data_o corrected data, m_tag_o tag
//   m_syndrome_o                per-lane {syndrome,parity} (P0_LSB=1) or {parity,syndrome}
//   m_sb_err_o/m_db_err_o       per-lane corrected / uncorrectable flags
//   cnt_clr_i, sb_cnt_o, db_cnt_o   error statistics (counted on output handshake)
//   log_clr_i, log_valid_o, log_tag_o, log_lane_o, log_syndrome_o   error log
module ecc_dec_pipe import ecc_pkg::*; #(
    parameter int unsigned K       = 8,
    parameter int unsigned LANES   = 2,
    parameter bit          P0_LSB  = 1'b1,
    parameter bit          PIPE    = 1'b1,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned M      = calc_m(K),
    localparam int unsigned N      = M + K,
    localparam int unsigned SW     = M + 1,
    localparam int unsigned LW     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [LANES*(N+1)-1:0] s_data_i,
    input  logic [TAG_W-1:0]       s_tag_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [LANES*K-1:0]     m_data_o,
    output logic [LANES*SW-1:0]    m_syndrome_o,
    output logic [LANES-1:0]       m_sb_err_o,
    output logic [LANES-1:0]       m_db_err_o,
    output logic [TAG_W-1:0]       m_tag_o,
    input  logic                   cnt_clr_i,
    output logic [CNT_W-1:0]       sb_cnt_o,
    output logic [CNT_W-1:0]       db_cnt_o,
    input  logic                   log_clr_i,
    output logic                   log_valid_o,
    output logic [TAG_W-1:0]       log_tag_o,
    output logic [LW-1:0]          log_lane_o,
    output logic [SW-1:0]          log_syndrome_o
);

    localparam int unsigned PW = $clog2(LANES + 1);
    localparam int unsigned AW = CNT_W + PW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [LANES*K-1:0]  q;
        logic [LANES*SW-1:0] syn;
        logic [LANES-1:0]    sb;
        logic [LANES-1:0]    db;
        logic [TAG_W-1:0]    tag;
    } beat_t;

    // ---------------- decode ----------------
    beat_t dec_beat;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [M-1:0] syn;
        logic         par;
        ecc_dec_lane #(
            .K      (K),
            .P0_LSB (P0_LSB)
        ) u_lane (
            .cw_i     (s_data_i[i*(N+1) +: N+1]),
            .q_o      (dec_beat.q[i*K +: K]),
            .syn_o    (syn),
            .parity_o (par),
            .sb_err_o (dec_beat.sb[i]),
            .db_err_o (dec_beat.db[i])
        );
        assign dec_beat.syn[i*SW +: SW] = P0_LSB ? {syn, par} : {par, syn};
    end

    assign dec_beat.tag = s_tag_i;

    // ---------------- pipeline ----------------
    logic  out_load;
    logic  st_valid;
    beat_t st_beat;
    logic  out_valid;
    beat_t out_beat;

    assign out_load = ~out_valid | m_ready_i;

    if (PIPE) begin : g_pipe
        logic  s1_valid;
        beat_t s1_beat;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                s1_valid <= 1'b0;
                s1_beat  <= '0;
            end else if (s_ready_o) begin
                s1_valid <= s_valid_i;
                s1_beat  <= dec_beat;
            end
        end

        // Stage 1 may accept whenever its current content moves on.
        assign s_ready_o = ~s1_valid | out_load;
        assign st_valid  = s1_valid;
        assign st_beat   = s1_beat;
    end else begin : g_nopipe
        assign s_ready_o = out_load;
        assign st_valid  = s_valid_i;
        assign st_beat   = dec_beat;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid <= 1'b0;
            out_beat  <= '0;
        end else if (out_load) begin
            out_valid <= st_valid;
            out_beat  <= st_beat;
        end
    end

    assign m_valid_o    = out_valid;
    assign m_data_o     = out_beat.q;
    assign m_syndrome_o = out_beat.syn;
    assign m_sb_err_o   = out_beat.sb;
    assign m_db_err_o   = out_beat.db;
    assign m_tag_o      = out_beat.tag;

    // ---------------- statistics ----------------
    logic          hs;
    logic [PW-1:0] sb_pop;
    logic [PW-1:0] db_pop;

    assign hs = out_valid & m_ready_i;

    always_comb begin
        sb_pop = '0;
        db_pop = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sb_pop += PW'(out_beat.sb[i]);
            db_pop += PW'(out_beat.db[i]);
        end
    end

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [PW-1:0] p);
        logic [AW-1:0] sum;
        sum = AW'(c) + AW'(p);
        if (sum > AW'(CNT_MAX)) begin
            return CNT_MAX;
        end
        return sum[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_cnt_o <= '0;
            db_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            // Clear wins: errors of a simultaneous handshake are dropped.
            sb_cnt_o <= '0;
            db_cnt_o <= '0;
        end else if (hs) begin
            sb_cnt_o <= sat_add(sb_cnt_o, sb_pop);
            db_cnt_o <= sat_add(db_cnt_o, db_pop);
        end
    end

    // ---------------- error log ----------------
    logic          log_take;
    logic          db_found;
    logic [LW-1:0] db_lane;
    logic [SW-1:0] db_syn;

    always_comb begin
        db_found = 1'b0;
        db_lane  = '0;
        db_syn   = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (!db_found && out_beat.db[i]) begin
                db_found = 1'b1;
                db_lane  = LW'(i);
                db_syn   = out_beat.syn[i*SW +: SW];
            end
        end
    end

    // A clear in the same cycle as a new error re-arms and captures at once.
    assign log_take = hs & db_found & (~log_valid_o | log_clr_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            log_valid_o    <= 1'b0;
            log_tag_o      <= '0;
            log_lane_o     <= '0;
            log_syndrome_o <= '0;
        end else if (log_take) begin
            log_valid_o    <= 1'b1;
            log_tag_o      <= out_beat.tag;
            log_lane_o     <= db_lane;
            log_syndrome_o <= db_syn;
        end else if (log_clr_i) begin
            log_valid_o    <= 1'b0;
            log_tag_o      <= '0;
            log_lane_o     <= '0;
            log_syndrome_o <= '0;
        end
    end

endmodule
